// File: rtl/pulse_meas.sv
// Measures one pulse against a start event: start-to-rise delay and high width, in BUS_CLK cycles.
// Byte-wide register interface; both inputs pass through matched synchronisers and edge detectors.
module pulse_meas #(
  parameter int         ABUSWIDTH = 16,
  parameter logic [7:0] VERSION   = 8'd1
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 EXT_START,
  input  logic                 PULSE_IN,
  output logic                 DONE
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_START = 3'd1,
    S_WAIT_RISE  = 3'd2,
    S_WAIT_FALL  = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        ext_meta_r, ext_sync_r, ext_prev_r;
  logic        pls_meta_r, pls_sync_r, pls_prev_r;
  logic        ext_rise_s, pls_val_s, pls_old_s, pls_rise_s, pls_fall_s;
  logic [1:0]  conf_r;
  logic [15:0] lim_r, lim_act_r;
  logic        inv_r;
  logic [15:0] delay_r, width_r, tcnt_r, tcnt_inc_s;
  logic        timeout_r, done_r, armed_r;
  logic        srst_s, arm_s, tout_hit_s, to_s;
  logic [7:0]  rdata_s;

  assign srst_s     = BUS_WR && (BUS_ADD == ABUSWIDTH'(0));
  assign arm_s      = BUS_WR && (BUS_ADD == ABUSWIDTH'(1)) && BUS_DATA_IN[0] &&
                      ((state_r == S_IDLE) || (state_r == S_DONE));
  assign tcnt_inc_s = tcnt_r + 16'd1;
  assign tout_hit_s = (lim_act_r != 16'd0) && (tcnt_inc_s == lim_act_r);

  // Inversion is applied to both the current and previous sample so a change of INV at arm never fakes an edge.
  assign ext_rise_s = ext_sync_r & ~ext_prev_r;
  assign pls_val_s  = pls_sync_r ^ inv_r;
  assign pls_old_s  = pls_prev_r ^ inv_r;
  assign pls_rise_s = pls_val_s & ~pls_old_s;
  assign pls_fall_s = ~pls_val_s & pls_old_s;

  assign DONE = done_r;

  // Input synchronisers and edge history; kept out of soft reset so a fresh arm cannot see a stale edge.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      {ext_meta_r, ext_sync_r, ext_prev_r} <= 3'b000;
      {pls_meta_r, pls_sync_r, pls_prev_r} <= 3'b000;
    end else begin
      ext_meta_r <= EXT_START;
      ext_sync_r <= ext_meta_r;
      ext_prev_r <= ext_sync_r;
      pls_meta_r <= PULSE_IN;
      pls_sync_r <= pls_meta_r;
      pls_prev_r <= pls_sync_r;
    end
  end

  // Bus-visible configuration registers.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      conf_r <= 2'b00;
      lim_r  <= 16'd0;
    end else if (srst_s) begin
      conf_r <= 2'b00;
      lim_r  <= 16'd0;
    end else if (BUS_WR) begin
      case (BUS_ADD)
        ABUSWIDTH'(2): conf_r      <= BUS_DATA_IN[1:0];
        ABUSWIDTH'(3): lim_r[7:0]  <= BUS_DATA_IN;
        ABUSWIDTH'(4): lim_r[15:8] <= BUS_DATA_IN;
        default:       conf_r      <= conf_r;
      endcase
    end else begin
      conf_r <= conf_r;
    end
  end

  // Measurement FSM next state; an edge takes priority over a coincident timeout.
  always_comb begin
    state_nxt_s = state_r;
    to_s        = 1'b0;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (arm_s) state_nxt_s = conf_r[0] ? S_WAIT_START : S_WAIT_RISE;
        else       state_nxt_s = state_r;
      end
      S_WAIT_START: begin
        if (ext_rise_s) state_nxt_s = S_WAIT_RISE;
        else            state_nxt_s = state_r;
      end
      S_WAIT_RISE: begin
        if (pls_rise_s) begin
          state_nxt_s = S_WAIT_FALL;
        end else if (tout_hit_s) begin
          state_nxt_s = S_DONE;
          to_s        = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      S_WAIT_FALL: begin
        if (pls_fall_s) begin
          state_nxt_s = S_DONE;
        end else if (tout_hit_s) begin
          state_nxt_s = S_DONE;
          to_s        = 1'b1;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FSM state, status flags, latched settings and saturating counters.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_r <= S_IDLE;  done_r  <= 1'b0;  armed_r   <= 1'b0;  timeout_r <= 1'b0;
      delay_r <= 16'd0;   width_r <= 16'd0; tcnt_r    <= 16'd0;
      inv_r   <= 1'b0;    lim_act_r <= 16'd0;
    end else if (srst_s) begin
      state_r <= S_IDLE;  done_r  <= 1'b0;  armed_r   <= 1'b0;  timeout_r <= 1'b0;
      delay_r <= 16'd0;   width_r <= 16'd0; tcnt_r    <= 16'd0;
      inv_r   <= 1'b0;    lim_act_r <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      done_r  <= (state_nxt_s == S_DONE);
      armed_r <= (state_nxt_s == S_WAIT_START) || (state_nxt_s == S_WAIT_RISE) ||
                 (state_nxt_s == S_WAIT_FALL);
      if (arm_s) begin
        delay_r   <= 16'd0;
        width_r   <= 16'd0;
        tcnt_r    <= 16'd0;
        timeout_r <= 1'b0;
        inv_r     <= conf_r[1];
        lim_act_r <= lim_r;
      end else if (state_r == S_WAIT_RISE) begin
        delay_r   <= (delay_r == 16'hFFFF) ? delay_r : delay_r + 16'd1;
        tcnt_r    <= tcnt_inc_s;
        timeout_r <= timeout_r | to_s;
      end else if (state_r == S_WAIT_FALL) begin
        width_r   <= (width_r == 16'hFFFF) ? width_r : width_r + 16'd1;
        tcnt_r    <= tcnt_inc_s;
        timeout_r <= timeout_r | to_s;
      end else begin
        tcnt_r <= tcnt_r;
      end
    end
  end

  // Read multiplexer.
  always_comb begin
    rdata_s = 8'h00;
    case (BUS_ADD)
      ABUSWIDTH'(0): rdata_s = VERSION;
      ABUSWIDTH'(1): rdata_s = {5'b00000, timeout_r, done_r, armed_r};
      ABUSWIDTH'(2): rdata_s = {6'b000000, conf_r};
      ABUSWIDTH'(3): rdata_s = lim_r[7:0];
      ABUSWIDTH'(4): rdata_s = lim_r[15:8];
      ABUSWIDTH'(5): rdata_s = delay_r[7:0];
      ABUSWIDTH'(6): rdata_s = delay_r[15:8];
      ABUSWIDTH'(7): rdata_s = width_r[7:0];
      ABUSWIDTH'(8): rdata_s = width_r[15:8];
      default:       rdata_s = 8'h00;
    endcase
  end

  // Registered read data, held until the next read strobe.
  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N)  BUS_DATA_OUT <= 8'h00;
    else if (srst_s) BUS_DATA_OUT <= 8'h00;
    else if (BUS_RD) BUS_DATA_OUT <= rdata_s;
    else             BUS_DATA_OUT <= BUS_DATA_OUT;
  end

endmodule

// File: tb/tb_pulse_meas.sv
// Directed and randomized bench for pulse_meas; expectations come from a cycle-count model of the measurement rules.
module tb_pulse_meas;

  logic        BUS_CLK = 1'b0;
  logic        BUS_RST_N = 1'b0;
  logic [15:0] BUS_ADD = 16'd0;
  logic [7:0]  BUS_DATA_IN = 8'd0;
  logic        BUS_RD = 1'b0;
  logic        BUS_WR = 1'b0;
  logic [7:0]  BUS_DATA_OUT;
  logic        EXT_START = 1'b0;
  logic        PULSE_IN = 1'b0;
  logic        DONE;

  int checks = 0;
  int failures = 0;

  pulse_meas #(.ABUSWIDTH(16), .VERSION(8'd1)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .BUS_ADD(BUS_ADD),
    .BUS_DATA_IN(BUS_DATA_IN), .BUS_RD(BUS_RD), .BUS_WR(BUS_WR),
    .BUS_DATA_OUT(BUS_DATA_OUT), .EXT_START(EXT_START), .PULSE_IN(PULSE_IN),
    .DONE(DONE)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  task automatic wr(input int addr, input int data);
    @(negedge BUS_CLK);
    BUS_ADD = 16'(addr); BUS_DATA_IN = 8'(data); BUS_WR = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [7:0] data);
    @(negedge BUS_CLK);
    BUS_ADD = 16'(addr); BUS_RD = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD = 1'b0;
    data = BUS_DATA_OUT;
  endtask

  task automatic rd16(input int addr, output logic [15:0] data);
    logic [7:0] lo, hi;
    rd(addr, lo);
    rd(addr + 1, hi);
    data = {hi, lo};
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (DONE !== 1'b1 && n < budget) begin
      @(negedge BUS_CLK);
      n++;
    end
    check(tag, {15'd0, DONE}, 16'd1);
  endtask

  // Edges sit at cycle counts k (rise) and k+w (fall) after the start; the timeout fires at count lim unless an edge lands there.
  task automatic model(input int k, input int w, input int lim, output int d, output int wd, output int to);
    if (lim != 0 && lim < k) begin
      to = 1; d = lim; wd = 0;
    end else if (lim != 0 && lim > k && lim < k + w) begin
      to = 1; d = k; wd = lim - k;
    end else begin
      to = 0; d = (k > 65535) ? 65535 : k; wd = (w > 65535) ? 65535 : w;
    end
  endtask

  task automatic run_ext(input string tag, input int k, input int w, input int lim);
    int d, wd, to;
    logic [7:0]  st;
    logic [15:0] v;
    model(k, w, lim, d, wd, to);
    wr(2, 1);
    wr(3, lim & 255);
    wr(4, (lim >> 8) & 255);
    wr(1, 1);
    cyc(2);
    EXT_START = 1'b1;
    cyc(k);
    PULSE_IN = 1'b1;
    cyc(w);
    PULSE_IN = 1'b0;
    EXT_START = 1'b0;
    wait_done({tag, "_done"}, 20);
    rd(1, st);
    check({tag, "_status"}, {8'd0, st}, (to != 0) ? 16'd6 : 16'd2);
    rd16(5, v);
    check({tag, "_delay"}, v, 16'(d));
    rd16(7, v);
    check({tag, "_width"}, v, 16'(wd));
    cyc(4);
  endtask

  initial begin
    logic [7:0]  b;
    logic [15:0] v;
    int k, w, lim;

    cyc(3);
    check("rst_done", {15'd0, DONE}, 16'd0);
    check("rst_dout", {8'd0, BUS_DATA_OUT}, 16'd0);
    BUS_RST_N = 1'b1;
    cyc(2);
    for (int a = 0; a <= 9; a++) begin
      rd(a, b);
      check($sformatf("rst_rd%0d", a), {8'd0, b}, (a == 0) ? 16'd1 : 16'd0);
    end
    check("rst_done2", {15'd0, DONE}, 16'd0);

    wr(2, 3);
    rd(2, b);
    check("conf_rb", {8'd0, b}, 16'd3);
    wr(3, 8'hA5);
    rd(3, b);
    check("lim_rb", {8'd0, b}, 16'hA5);
    wr(3, 0);

    run_ext("basic", 20, 37, 0);

    for (int i = 0; i < 10; i++) begin
      k = int'($urandom_range(1, 40));
      w = int'($urandom_range(1, 40));
      lim = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(5, 90));
      if (lim == k) lim = lim + 1;
      run_ext($sformatf("rnd%0d", i), k, w, lim);
    end

    // Pulse already high at arm: only the later edge counts.
    wr(2, 0); wr(3, 0); wr(4, 0);
    PULSE_IN = 1'b1;
    cyc(5);
    wr(1, 1);
    cyc(5);
    PULSE_IN = 1'b0;
    cyc(4);
    PULSE_IN = 1'b1;
    cyc(5);
    PULSE_IN = 1'b0;
    wait_done("prehigh_done", 20);
    rd16(7, v);
    check("prehigh_width", v, 16'd5);

    wr(3, 100);
    wr(1, 1);
    cyc(99);
    check("to_early", {15'd0, DONE}, 16'd0);
    cyc(1);
    check("to_done", {15'd0, DONE}, 16'd1);
    rd(1, b);
    check("to_status", {8'd0, b}, 16'd6);
    rd16(5, v);
    check("to_delay", v, 16'd100);
    rd16(7, v);
    check("to_width", v, 16'd0);

    // Inverted input with a low-going pulse.
    PULSE_IN = 1'b1;
    cyc(4);
    wr(2, 2);
    wr(1, 1);
    cyc(6);
    PULSE_IN = 1'b0;
    cyc(8);
    PULSE_IN = 1'b1;
    wait_done("inv_done", 20);
    rd(1, b);
    check("inv_status", {8'd0, b}, 16'd2);
    rd16(7, v);
    check("inv_width", v, 16'd8);
    PULSE_IN = 1'b0;
    cyc(4);

    wr(2, 0); wr(3, 0);
    wr(1, 1);
    cyc(3);
    PULSE_IN = 1'b1;
    cyc(70000);
    PULSE_IN = 1'b0;
    wait_done("sat_done", 20);
    rd(1, b);
    check("sat_status", {8'd0, b}, 16'd2);
    rd16(7, v);
    check("sat_width", v, 16'hFFFF);
    cyc(4);

    // Second arm in WAIT_RISE must not restart the timeout count.
    wr(3, 50);
    wr(1, 1);
    cyc(10);
    wr(1, 1);
    cyc(37);
    check("rearm_early", {15'd0, DONE}, 16'd0);
    cyc(1);
    check("rearm_done", {15'd0, DONE}, 16'd1);
    rd16(5, v);
    check("rearm_delay", v, 16'd50);

    wr(2, 0); wr(3, 0); wr(4, 8'h12);
    wr(1, 1);
    cyc(3);
    PULSE_IN = 1'b1;
    cyc(10);
    rd(1, b);
    check("srst_pre_status", {8'd0, b}, 16'd1);
    wr(0, 8'h5A);
    rd(1, b);
    check("srst_status", {8'd0, b}, 16'd0);
    rd16(5, v);
    check("srst_delay", v, 16'd0);
    rd16(7, v);
    check("srst_width", v, 16'd0);
    rd(4, b);
    check("srst_lim", {8'd0, b}, 16'd0);
    check("srst_done", {15'd0, DONE}, 16'd0);
    PULSE_IN = 1'b0;
    cyc(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
